// File: rtl/rtlpconfig_bank.sv
// rtlpconfig_bank: register bank with RW/RO/W1C registers, programmable ready latency,
// an address-error flag and a sticky-event interrupt.
module rtlpconfig_bank #(
    parameter int                        WIDTH       = 8,
    parameter int                        NREG        = 4,
    parameter int                        ADDR_W      = 8,
    parameter logic [NREG*WIDTH-1:0]     RESET_VALUE = '0,
    parameter logic [NREG-1:0]           RO_MASK     = '0,
    parameter logic [NREG-1:0]           W1C_MASK    = '0,
    parameter int                        RDY_LAT     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     upen,
    input  logic                     upws,
    input  logic                     uprs,
    input  logic [ADDR_W-1:0]        upa,
    input  logic [WIDTH-1:0]         updi,
    input  logic [NREG*WIDTH-1:0]    hwsts,
    input  logic [NREG*WIDTH-1:0]    hwevt,
    output logic [NREG*WIDTH-1:0]    out,
    output logic                     uprdy,
    output logic [WIDTH-1:0]         updo,
    output logic                     uperr,
    output logic                     irq
);
    localparam int CW = $clog2(RDY_LAT) + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [ADDR_W-1:0]       addr_q;
    logic                    wr_q;
    logic [NREG*WIDTH-1:0]   regs;
    logic [NREG*WIDTH-1:0]   regs_nxt;
    logic [NREG*WIDTH-1:0]   w1c_bits;
    logic [WIDTH-1:0]        rd_val;
    logic [ADDR_W-1:0]       addr;
    logic                    idle;
    logic                    strobe;
    logic                    commit;
    logic                    err;

    assign idle   = state == IDLE;
    assign strobe = upen & (upws | uprs);
    assign commit = idle & strobe & upws;
    // The acknowledge cycle decodes the latched address once the access is in flight.
    assign addr   = idle ? upa : addr_q;
    assign err    = 32'(addr) >= 32'(NREG);
    assign out    = regs;

    always_comb begin
        regs_nxt = regs;
        w1c_bits = '0;
        rd_val   = '0;
        for (int i = 0; i < NREG; i++) begin
            if (32'(addr) == i) rd_val = regs[i*WIDTH +: WIDTH];
            if (RO_MASK[i]) begin
                regs_nxt[i*WIDTH +: WIDTH] = hwsts[i*WIDTH +: WIDTH];
            end else if (W1C_MASK[i]) begin
                w1c_bits[i*WIDTH +: WIDTH] = regs[i*WIDTH +: WIDTH];
                // Event set is OR-ed after the clear so a simultaneous event wins.
                regs_nxt[i*WIDTH +: WIDTH] = (regs[i*WIDTH +: WIDTH] &
                    ~((commit && 32'(upa) == i) ? updi : '0)) | hwevt[i*WIDTH +: WIDTH];
            end else if (commit && 32'(upa) == i) begin
                regs_nxt[i*WIDTH +: WIDTH] = updi;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            wr_q   <= 1'b0;
            regs   <= RESET_VALUE;
            uprdy  <= 1'b0;
            updo   <= '0;
            uperr  <= 1'b0;
            irq    <= 1'b0;
        end else begin
            regs  <= regs_nxt;
            irq   <= |w1c_bits;
            uprdy <= 1'b0;
            updo  <= '0;
            uperr <= 1'b0;
            if (idle) begin
                if (strobe) begin
                    addr_q <= upa;
                    wr_q   <= upws;
                    if (RDY_LAT <= 1) begin
                        uprdy <= 1'b1;
                        uperr <= err;
                        updo  <= (upws || err) ? '0 : rd_val;
                    end else begin
                        state <= WAIT;
                        cnt   <= CW'(1);
                    end
                end
            end else if (cnt == CW'(RDY_LAT - 1)) begin
                state <= IDLE;
                cnt   <= '0;
                uprdy <= 1'b1;
                uperr <= err;
                updo  <= (wr_q || err) ? '0 : rd_val;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_rtlpconfig_bank.sv
// tb_rtlpconfig_bank: drives two banks (ready latency 1 and 4) with shared stimulus and
// checks them against a cycle-level model of the register rules.
module tb_rtlpconfig_bank;
    localparam logic [31:0] RV  = 32'hA5003C11;
    localparam logic [3:0]  ROM = 4'b1000;
    localparam logic [3:0]  W1M = 4'b1010;

    logic        clk = 1'b0, rst = 1'b0;
    logic        upen1 = 1'b0, upen4 = 1'b0, upws = 1'b0, uprs = 1'b0;
    logic [7:0]  upa = '0, updi = '0;
    logic [31:0] hwsts = 32'hA500_0000, hwevt = '0;
    logic [31:0] out1, out4;
    logic        uprdy1, uprdy4, uperr1, uperr4, irq1, irq4;
    logic [7:0]  updo1, updo4;
    logic [31:0] m = RV, pre = RV;
    logic        irq_m = 1'b0;
    bit          rnd_hw = 1'b0;
    int          checks = 0, passed = 0, fails = 0;
    logic [7:0]  got;
    logic [7:0]  rexp [4] = '{8'h11, 8'h3C, 8'h00, 8'hA5};

    always #5 clk = ~clk;

    rtlpconfig_bank #(.WIDTH(8), .NREG(4), .ADDR_W(8), .RESET_VALUE(RV), .RO_MASK(ROM),
                      .W1C_MASK(W1M), .RDY_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .upen(upen1), .upws(upws), .uprs(uprs), .upa(upa), .updi(updi),
        .hwsts(hwsts), .hwevt(hwevt), .out(out1), .uprdy(uprdy1), .updo(updo1),
        .uperr(uperr1), .irq(irq1));

    rtlpconfig_bank #(.WIDTH(8), .NREG(4), .ADDR_W(8), .RESET_VALUE(RV), .RO_MASK(ROM),
                      .W1C_MASK(W1M), .RDY_LAT(4)) dut4 (
        .clk(clk), .rst(rst), .upen(upen4), .upws(upws), .uprs(uprs), .upa(upa), .updi(updi),
        .hwsts(hwsts), .hwevt(hwevt), .out(out4), .uprdy(uprdy4), .updo(updo4),
        .uperr(uperr4), .irq(irq4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model by the register rules, then compare contents and irq.
    task automatic tick(input bit acc);
        @(posedge clk);
        pre = m;
        irq_m = 1'b0;
        if (!rst) begin
            m = RV;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ROM[i]) m[i*8 +: 8] = hwsts[i*8 +: 8];
                else if (W1M[i]) begin
                    irq_m = irq_m | (|pre[i*8 +: 8]);
                    m[i*8 +: 8] = (pre[i*8 +: 8] &
                        ~((acc && upws && upa == 8'(i)) ? updi : 8'h00)) | hwevt[i*8 +: 8];
                end else if (acc && upws && upa == 8'(i)) m[i*8 +: 8] = updi;
            end
        end
        #1;
        check("out1", out1, m);
        check("out4", out4, m);
        check("irq1", 32'(irq1), 32'(irq_m));
        check("irq4", 32'(irq4), 32'(irq_m));
    endtask

    // Strobe for one cycle, then watch both acknowledges over five edges.
    task automatic access(input bit we, input bit rd, input logic [7:0] a, input logic [7:0] d,
                          input bit dbl, output logic [7:0] rdat);
        logic [7:0] e;
        upen1 = 1'b1; upen4 = 1'b1; upws = we; uprs = rd; upa = a; updi = d;
        rdat = '0;
        for (int k = 0; k < 5; k++) begin
            tick(k == 0);
            e = (we || a >= 8'd4) ? 8'h00 : pre[a[1:0]*8 +: 8];
            if (k == 0) rdat = updo1;
            check("uprdy1", 32'(uprdy1), 32'(k == 0));
            check("updo1", 32'(updo1), 32'(k == 0 ? e : 8'h00));
            check("uperr1", 32'(uperr1), 32'(k == 0 && a >= 8'd4));
            check("uprdy4", 32'(uprdy4), 32'(k == 3));
            check("updo4", 32'(updo4), 32'(k == 3 ? e : 8'h00));
            check("uperr4", 32'(uperr4), 32'(k == 3 && a >= 8'd4));
            upen1 = 1'b0; upen4 = 1'b0; upws = 1'b0; uprs = 1'b0;
            if (k == 0 && dbl) begin
                upen4 = 1'b1; upws = 1'b1; upa = 8'h00; updi = ~m[7:0];
            end
            if (rnd_hw) begin
                hwsts = $urandom;
                hwevt = $urandom & $urandom & $urandom;
            end else if (k == 0) hwevt = '0;
        end
    endtask

    initial begin
        tick(0);
        tick(0);
        check("rst_uprdy1", 32'(uprdy1), 32'd0);
        check("rst_uprdy4", 32'(uprdy4), 32'd0);
        check("rst_out1", out1, RV);
        rst = 1'b1;
        for (int a = 0; a < 4; a++) begin
            access(1'b0, 1'b1, 8'(a), 8'h00, 1'b0, got);
            check("reset_read", 32'(got), 32'(rexp[a]));
        end
        access(1'b1, 1'b0, 8'd2, 8'h5A, 1'b0, got);
        check("rw_write", 32'(out1[23:16]), 32'h5A);
        access(1'b0, 1'b1, 8'd2, 8'h00, 1'b0, got);
        check("rw_readback", 32'(got), 32'h5A);
        access(1'b1, 1'b1, 8'd0, 8'h66, 1'b0, got);
        check("both_strobes", 32'(out1[7:0]), 32'h66);
        access(1'b1, 1'b0, 8'd2, 8'h77, 1'b1, got);
        check("busy_strobe4", 32'(out4), {8'hA5, 8'h77, 8'h3C, 8'h66});
        access(1'b1, 1'b0, 8'd1, 8'hFF, 1'b0, got);
        tick(0);
        check("w1c_cleared", 32'(out1[15:8]), 32'h00);
        check("irq_low", 32'(irq1), 32'd0);
        hwevt = 32'h0000_0100;
        tick(0);
        hwevt = '0;
        check("w1c_set", 32'(out1[8]), 32'd1);
        tick(0);
        check("irq_high", 32'(irq1), 32'd1);
        hwevt = 32'h0000_0100;
        access(1'b1, 1'b0, 8'd1, 8'h01, 1'b0, got);
        check("set_wins", 32'(out1[15:8]), 32'h01);
        access(1'b1, 1'b0, 8'd1, 8'h01, 1'b0, got);
        check("w1c_clear", 32'(out1[15:8]), 32'h00);
        check("irq_fell", 32'(irq4), 32'd0);
        hwsts = 32'hC300_0000;
        tick(0);
        access(1'b1, 1'b0, 8'd3, 8'hFF, 1'b0, got);
        check("ro_write", 32'(out1[31:24]), 32'hC3);
        hwevt = 32'h0F00_0000;
        tick(0);
        hwevt = '0;
        access(1'b0, 1'b1, 8'd3, 8'h00, 1'b0, got);
        check("ro_read", 32'(got), 32'hC3);
        access(1'b0, 1'b1, 8'd7, 8'h00, 1'b0, got);
        check("err_read", 32'(got), 32'h00);
        access(1'b0, 1'b1, 8'd4, 8'h00, 1'b0, got);
        access(1'b1, 1'b0, 8'h84, 8'h12, 1'b0, got);
        check("err_write", out4, {8'hC3, 8'h77, 8'h00, 8'h66});
        // Reset while the latency-4 bank is waiting to acknowledge.
        upen1 = 1'b1; upen4 = 1'b1; uprs = 1'b1; upa = 8'd0;
        tick(1);
        upen1 = 1'b0; upen4 = 1'b0; uprs = 1'b0;
        tick(0);
        #2 rst = 1'b0;
        #1;
        check("wait_rst_out", out4, RV);
        check("wait_rst_uprdy", 32'(uprdy4), 32'd0);
        check("wait_rst_updo", 32'(updo4), 32'd0);
        check("wait_rst_uperr", 32'(uperr4), 32'd0);
        check("wait_rst_irq", 32'(irq4), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick(0);
            check("no_ack_after_rst", 32'(uprdy4), 32'd0);
        end
        rst = 1'b1;
        access(1'b0, 1'b1, 8'd1, 8'h00, 1'b0, got);
        check("post_rst_read", 32'(got), 32'h3C);
        rnd_hw = 1'b1;
        repeat (60) begin
            logic we, rd;
            we = 1'($urandom_range(0, 1));
            rd = we ? 1'($urandom_range(0, 1)) : 1'b1;
            access(we, rd, 8'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3) == 0, got);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
